reference_reader: RTL

- Requesting end of the reference sample buffer.
- On `start`, sweeps index 0..buffer_length-1 into the buffer's index port and captures the I/Q word the buffer returns one cycle later.
- Re-streams captured samples downstream through a small credit-managed FIFO, with backpressure and a `tlast` on the final sample.
- Sits between the sweep controller and the correlator datapath.

---
 rtl/reference_reader_if.sv | 34 +++
 rtl/reference_reader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reference_reader_if.sv
// Stream bundle between the reference reader, the sample buffer and the
// correlator: index request out, sample return in, {I,Q} stream out.
interface reference_reader_if #(
    parameter int buffer_bits = 4,
    parameter int i_bits      = 12,
    parameter int q_bits      = 12
);
    logic                     index_tvalid;
    logic [buffer_bits-1:0]   index_tdata;
    logic                     index_tready;
    logic                     sample_tvalid;
    logic [i_bits-1:0]        sample_i;
    logic [q_bits-1:0]        sample_q;
    logic                     out_tvalid;
    logic [i_bits+q_bits-1:0] out_tdata;
    logic                     out_tlast;
    logic                     out_tready;

    modport master (
        output index_tvalid, index_tdata,
        input  index_tready,
        input  sample_tvalid, sample_i, sample_q,
        output out_tvalid, out_tdata, out_tlast,
        input  out_tready
    );

    modport slave (
        input  index_tvalid, index_tdata,
        output index_tready,
        output sample_tvalid, sample_i, sample_q,
        input  out_tvalid, out_tdata, out_tlast,
        output out_tready
    );
endinterface

// File: rtl/reference_reader.sv
// Sweeps the reference buffer index range and re-streams the returned I/Q
// words through a credit-managed FIFO, so a returned sample always has a slot.
module reference_reader #(
    parameter int buffer_length = 10,
    parameter int buffer_bits   = 4,
    parameter int i_bits        = 12,
    parameter int q_bits        = 12,
    parameter int fifo_depth    = 4,
    parameter int fifo_bits     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic error,
    reference_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    typedef struct packed {
        logic [i_bits-1:0] i;
        logic [q_bits-1:0] q;
        logic              last;
    } entry_t;

    typedef logic [fifo_bits-1:0] ptr_t;
    typedef logic [fifo_bits:0]   cnt_t;
    typedef logic [fifo_bits+1:0] credit_t;

    localparam logic [buffer_bits-1:0] last_idx = buffer_bits'(buffer_length - 1);

    state_t                 state, state_nx;
    logic [buffer_bits-1:0] idx, idx_nx;
    logic                   inflight;
    logic                   last_sh;
    logic                   error_q;
    logic                   index_tvalid;
    logic                   xfer, push, pop, credit, empty;

    entry_t mem [fifo_depth];
    ptr_t   wr_ptr, rd_ptr;
    cnt_t   count;
    entry_t head;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(fifo_depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Outstanding requests count against FIFO space before their data arrives.
    assign credit = (credit_t'(count) + credit_t'(inflight)) < credit_t'(fifo_depth);
    assign empty  = (count == '0);
    assign xfer   = index_tvalid & bus.index_tready;
    // An unsolicited sample has no reserved slot and is dropped.
    assign push   = bus.sample_tvalid & inflight;
    assign pop    = bus.out_tvalid & bus.out_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        index_tvalid = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SWEEP;
                    idx_nx   = '0;
                end
            end
            SWEEP: begin
                index_tvalid = credit;
                if (credit && bus.index_tready) begin
                    if (idx == last_idx) state_nx = DRAIN;
                    else                 idx_nx   = idx + buffer_bits'(1);
                end
            end
            DRAIN: begin
                if (empty && !inflight && !bus.sample_tvalid) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && !done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            last_sh  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            inflight <= xfer;
            if (xfer) last_sh <= (idx == last_idx);
            if ((bus.sample_tvalid && !inflight) || (inflight && !bus.sample_tvalid))
                error_q <= 1'b1;
        end
    end

    assign error = error_q;

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{i: bus.sample_i, q: bus.sample_q, last: last_sh};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    assign head             = mem[rd_ptr];
    assign bus.out_tvalid   = !empty;
    assign bus.out_tdata    = empty ? '0 : {head.i, head.q};
    assign bus.out_tlast    = !empty && head.last;
    assign bus.index_tvalid = index_tvalid;
    assign bus.index_tdata  = idx;
endmodule
